// File: rtl/i2c_poll_pkg.sv
// Shared types and field offsets for the I2C polling sequencer.
package i2c_poll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PTR_REQ,
    PTR_WAIT,
    RD_REQ,
    RD_WAIT,
    PUSH
  } state_t;

  localparam int unsigned NBYTES_MAX = 3;

  // cfg_data layout
  localparam int unsigned CFG_ADDR_LSB  = 0;
  localparam int unsigned CFG_PTR_LSB   = 8;
  localparam int unsigned CFG_NB_LSB    = 16;
  localparam int unsigned CFG_VALID_BIT = 31;

  // result word layout
  localparam int unsigned RES_SLOT_LSB = 28;
  localparam int unsigned RES_ERR_BIT  = 27;
  localparam int unsigned RES_TMO_BIT  = 26;
  localparam int unsigned RES_CNT_LSB  = 24;

  // 18-bit table entry
  typedef struct packed {
    logic       valid;
    logic [1:0] nbytes;
    logic [7:0] ptr;
    logic [6:0] addr;
  } entry_t;

endpackage

// File: rtl/i2c_poll_slot_table.sv
// Slot table: SLOTS x 18-bit registers, one write port, one combinational read port.
module i2c_poll_slot_table
  import i2c_poll_pkg::*;
#(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned IDX_W = $clog2(SLOTS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_slot,
  input  entry_t           wr_entry,
  input  logic [IDX_W-1:0] rd_slot,
  output entry_t           rd_entry
);

  entry_t table_q [SLOTS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SLOTS; i++) table_q[i] <= '0;
    end else if (we) begin
      table_q[wr_slot] <= wr_entry;
    end
  end

  assign rd_entry = table_q[rd_slot];

endmodule

// File: rtl/i2c_poll_sequencer.sv
// Periodic I2C sensor poller: pointer write + 1..3 byte read per valid slot, one tagged word per slot.
// Optional transaction watchdog enabled by defining I2C_POLL_TIMEOUT_EN.
module i2c_poll_sequencer
  import i2c_poll_pkg::*;
#(
  parameter int unsigned SLOTS          = 8,
  parameter int unsigned PERIOD_W       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     cfg_we,
  input  logic [$clog2(SLOTS)-1:0] cfg_slot,
  input  logic [31:0]              cfg_data,
  output logic                     m_ena,
  output logic                     m_rw,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_data_wr,
  input  logic                     m_busy,
  input  logic                     m_ack_error,
  input  logic                     m_byte_valid,
  input  logic [7:0]               m_data_rd,
  output logic [31:0]              res_data,
  output logic                     res_wrreq,
  input  logic                     res_full,
  output logic                     sweeping,
  output logic                     overrun
);

  localparam int unsigned IDX_W = $clog2(SLOTS);

  if (SLOTS < 2 || SLOTS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("i2c_poll_sequencer: SLOTS must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  state_t              state;
  logic [IDX_W:0]      idx;
  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] per_eff;
  logic                tick;
  logic [1:0]          nbytes;
  logic [1:0]          rcv_cnt;
  logic                ack_seen;
  entry_t              wr_entry;
  entry_t              rd_entry;
  logic                unused_cfg;

  assign wr_entry = '{valid:  cfg_data[CFG_VALID_BIT],
                      nbytes: cfg_data[CFG_NB_LSB +: 2],
                      ptr:    cfg_data[CFG_PTR_LSB +: 8],
                      addr:   cfg_data[CFG_ADDR_LSB +: 7]};
  assign unused_cfg = ^{cfg_data[30:18], cfg_data[7]};

  i2c_poll_slot_table #(.SLOTS(SLOTS), .IDX_W(IDX_W)) u_table (
    .clock    (clock),
    .reset    (reset),
    .we       (cfg_we),
    .wr_slot  (cfg_slot),
    .wr_entry (wr_entry),
    .rd_slot  (idx[IDX_W-1:0]),
    .rd_entry (rd_entry)
  );

  // Up-counter cleared at reset is equivalent to loading 'period': first tick lands 'period' cycles after run rises.
  assign per_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign tick    = run && (per_cnt >= per_eff - PERIOD_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             per_cnt <= '0;
    else if (!run || tick) per_cnt <= '0;
    else                   per_cnt <= per_cnt + PERIOD_W'(1);
  end

`ifdef I2C_POLL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;
  logic            wd_expired;
  assign wd_expired = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic wd_expired;
  assign wd_expired = 1'b0;
`endif

  assign rcv_cnt = res_data[RES_CNT_LSB +: 2];

  // Combinational so the single write cycle is always one in which the FIFO is not full.
  assign res_wrreq = (state == PUSH) && !res_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      m_ena     <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_data_wr <= '0;
      res_data  <= '0;
      sweeping  <= 1'b0;
      overrun   <= 1'b0;
      nbytes    <= '0;
      ack_seen  <= 1'b0;
`ifdef I2C_POLL_TIMEOUT_EN
      wdog      <= '0;
`endif
    end else begin
      if (!run)                 overrun <= 1'b0;
      else if (tick && sweeping) overrun <= 1'b1;

      if ((state == RD_REQ || state == RD_WAIT) && m_byte_valid && (rcv_cnt < nbytes)) begin
        res_data[8*rcv_cnt +: 8]     <= m_data_rd;
        res_data[RES_CNT_LSB +: 2]   <= rcv_cnt + 2'd1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            idx      <= '0;
            sweeping <= 1'b1;
            state    <= SELECT;
          end
        end
        SELECT: begin
          if (!run || idx == (IDX_W+1)'(SLOTS)) begin
            sweeping <= 1'b0;
            state    <= IDLE;
          end else if (!rd_entry.valid || rd_entry.nbytes == 2'd0) begin
            idx <= idx + 1'b1;
          end else begin
            nbytes    <= rd_entry.nbytes;
            m_addr    <= rd_entry.addr;
            m_data_wr <= rd_entry.ptr;
            m_rw      <= 1'b0;
            m_ena     <= 1'b1;
            res_data  <= {4'(idx), 28'h0};
            state     <= PTR_REQ;
          end
        end
        PTR_REQ, RD_REQ: begin
          if (m_busy) begin
            m_ena    <= 1'b0;
            ack_seen <= 1'b0;
`ifdef I2C_POLL_TIMEOUT_EN
            wdog     <= '0;
`endif
            state    <= (state == PTR_REQ) ? PTR_WAIT : RD_WAIT;
          end
        end
        PTR_WAIT, RD_WAIT: begin
          if (!m_busy) begin
            if (ack_seen || m_ack_error) begin
              res_data[RES_ERR_BIT] <= 1'b1;
              state                 <= PUSH;
            end else if (state == PTR_WAIT) begin
              m_rw  <= 1'b1;
              m_ena <= 1'b1;
              state <= RD_REQ;
            end else begin
              state <= PUSH;
            end
          end else if (wd_expired) begin
            res_data[RES_ERR_BIT] <= 1'b1;
            res_data[RES_TMO_BIT] <= 1'b1;
            m_ena                 <= 1'b0;
            state                 <= PUSH;
          end else begin
            ack_seen <= ack_seen | m_ack_error;
`ifdef I2C_POLL_TIMEOUT_EN
            wdog     <= wdog + 1'b1;
`endif
          end
        end
        PUSH: begin
          if (!res_full) begin
            idx <= idx + 1'b1;
            if (run) begin
              state <= SELECT;
            end else begin
              sweeping <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
